mpsse_i2c_master: RTL and testbench

// - Synthesizable byte-level I2C master, modelled on an FTDI-MPSSE-style bench master.
// - Converts single-byte commands into open-drain SCK/SDO waveforms: START, STOP, WRITE (with slave ACK sample) and READ (with master ACK/NACK).
// - Drives the DUT's I2C port (SCL/SDA), or the CC or D+/D- pins when they are muxed to I2C.

---
 rtl/mpsse_i2c_master.sv | 169 ++++++++++++++++
 tb/tb_mpsse_i2c_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsse_i2c_master.sv
// Byte-level open-drain I2C master: START, STOP, WRITE (slave ACK sample) and READ (master ACK/NACK).
// Define I2C_STRETCH_EN to let a slave stretch SCK during the release quarter of every bit.
module mpsse_i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdat,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdat,
  output logic       rsp_nack,
  output logic       CSB,
  inout  tri         SCK,
  inout  tri         SDO,
  input  logic       SDI
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [2:0] {IDLE, START, STOP, WBIT, RBIT, ACKW, ACKR} state_t;

  state_t          state, state_d;
  logic [QW-1:0]   qcnt, qcnt_d;
  logic [1:0]      phase, phase_d;
  logic [2:0]      bit_cnt, bit_cnt_d;
  logic [7:0]      shreg, shreg_d;
  logic            ack_lvl, ack_d;
  logic            sck_oe, sck_oe_d;   // 1 = pull SCK low
  logic            sdo_oe, sdo_oe_d;   // 1 = pull SDO low
  logic            csb_d, valid_d, nack_d;
  logic [7:0]      rdat_d;
  logic            accept, tick, stall;

`ifdef I2C_STRETCH_EN
  assign stall = (state != IDLE) && (phase == 2'd1) && (SCK == 1'b0);
`else
  assign stall = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign tick      = (state != IDLE) && !stall && (qcnt == QLAST);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves a value unassigned, which would infer a latch.
    state_d   = state;
    qcnt_d    = qcnt;
    phase_d   = phase;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    ack_d     = ack_lvl;
    sck_oe_d  = sck_oe;
    sdo_oe_d  = sdo_oe;
    csb_d     = CSB;
    valid_d   = 1'b0;
    rdat_d    = rsp_rdat;
    nack_d    = rsp_nack;

    if (accept) begin
      qcnt_d    = '0;
      phase_d   = 2'd0;
      bit_cnt_d = 3'd7;
      shreg_d   = cmd_wdat;
      ack_d     = cmd_ack;
      case (cmd_op)
        OP_START: begin state_d = START; csb_d = 1'b0; end
        OP_STOP:  state_d = STOP;
        OP_WRITE: state_d = WBIT;
        default:  state_d = RBIT;
      endcase
    end else if ((state != IDLE) && !stall) begin
      qcnt_d = tick ? '0 : qcnt + 1'b1;
      if (tick) begin
        phase_d = phase + 2'd1;
        // The slave ACK shares the shift register: it lands in bit 0 after the eight data shifts.
        if (phase == 2'd1 && (state == RBIT || state == ACKW))
          shreg_d = {shreg[6:0], SDI};
        if (phase == 2'd3) begin
          case (state)
            STOP: begin state_d = IDLE; csb_d = 1'b1; end
            WBIT: begin
              shreg_d = {shreg[6:0], 1'b0};
              if (bit_cnt == 3'd0) state_d = ACKW;
              else                 bit_cnt_d = bit_cnt - 3'd1;
            end
            RBIT: begin
              if (bit_cnt == 3'd0) state_d = ACKR;
              else                 bit_cnt_d = bit_cnt - 3'd1;
            end
            ACKW: begin state_d = IDLE; valid_d = 1'b1; nack_d = shreg[0]; end
            ACKR: begin state_d = IDLE; valid_d = 1'b1; rdat_d = shreg; end
            default: state_d = IDLE;
          endcase
        end
      end
    end

    // Line drives change only on quarter entry and are otherwise held, also across IDLE.
    if (accept || (tick && state_d != IDLE)) begin
      case (state_d)
        START: case (phase_d)
          2'd0:    sdo_oe_d = 1'b0;
          2'd1:    sck_oe_d = 1'b0;
          2'd2:    sdo_oe_d = 1'b1;
          default: sck_oe_d = 1'b1;
        endcase
        STOP: case (phase_d)
          2'd0:    sdo_oe_d = 1'b1;
          2'd1:    sck_oe_d = 1'b0;
          2'd2:    sdo_oe_d = 1'b0;
          default: ;
        endcase
        default: case (phase_d)
          2'd0: begin
            sck_oe_d = 1'b1;
            sdo_oe_d = (state_d == WBIT) ? !shreg_d[7] : (state_d == ACKR) ? ack_d : 1'b0;
          end
          2'd1:    sck_oe_d = 1'b0;
          2'd3:    sck_oe_d = 1'b1;
          default: ;
        endcase
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      ack_lvl   <= 1'b0;
      sck_oe    <= 1'b0;
      sdo_oe    <= 1'b0;
      CSB       <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdat  <= 8'h00;
      rsp_nack  <= 1'b0;
    end else begin
      state     <= state_d;
      qcnt      <= qcnt_d;
      phase     <= phase_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      ack_lvl   <= ack_d;
      sck_oe    <= sck_oe_d;
      sdo_oe    <= sdo_oe_d;
      CSB       <= csb_d;
      rsp_valid <= valid_d;
      rsp_rdat  <= rdat_d;
      rsp_nack  <= nack_d;
    end
  end

  assign SCK = sck_oe ? 1'b0 : 1'bz;
  assign SDO = sdo_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mpsse_i2c_master.sv
// Bench for mpsse_i2c_master: waveform model indexed by cycle-in-command, per-cycle compare, and literal spot checks.
module tb_mpsse_i2c_master;

  localparam int CD = 4;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;
`ifdef I2C_STRETCH_EN
  localparam int STRETCH_LEN = 164;
`else
  localparam int STRETCH_LEN = 144;
`endif

  logic       clk, rst;
  logic       cmd_valid, cmd_ready, cmd_ack;
  logic [1:0] cmd_op;
  logic [7:0] cmd_wdat, rsp_rdat;
  logic       rsp_valid, rsp_nack, csb;
  wire        sck_bus, sdo_bus;
  logic       slave_sck_low, slave_sdo_low;
  wire        sdi;

  assign sck_bus = slave_sck_low ? 1'b0 : 1'bz;
  assign sdo_bus = slave_sdo_low ? 1'b0 : 1'bz;
  pullup (sck_bus);
  pullup (sdo_bus);
  assign sdi = sdo_bus;

  mpsse_i2c_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wdat(cmd_wdat), .cmd_ack(cmd_ack),
    .rsp_valid(rsp_valid), .rsp_rdat(rsp_rdat), .rsp_nack(rsp_nack),
    .CSB(csb), .SCK(sck_bus), .SDO(sdo_bus), .SDI(sdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Expected bus levels and outputs for the current cycle
  logic       chk_en = 1'b0;
  logic       exp_sck, exp_sdo, exp_csb, exp_ready, exp_valid, exp_nack;
  logic [7:0] exp_rdat;
  logic       m_sck;          // SCK level the master last left on the bus
  logic [8:0] cap;            // SDO sampled at each SCK rise
  logic       cap_en = 1'b0;
  logic       rise_sck;
  logic       rise_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Master line levels (1 = released) during cycle k of a command, from the quarter-phase rules.
  function automatic logic [1:0] wave(input logic [1:0] op, input logic [7:0] wdat,
                                      input logic ack, input int k, input logic psck);
    int   ph, b;
    logic bv;
    ph = (k / CD) % 4;
    b  = k / (4 * CD);
    case (op)
      OP_START: case (ph)
        0:       return {psck, 1'b1};
        1:       return 2'b11;
        2:       return 2'b10;
        default: return 2'b00;
      endcase
      OP_STOP: case (ph)
        0:       return {psck, 1'b0};
        1:       return 2'b10;
        default: return 2'b11;
      endcase
      default: begin
        if (b < 8) bv = (op == OP_WRITE) ? wdat[7-b] : 1'b1;
        else       bv = (op == OP_WRITE) ? 1'b1 : !ack;
        return {(ph == 1 || ph == 2), bv};
      end
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("sck",       sck_bus,   exp_sck);
      check("sdo",       sdo_bus,   exp_sdo);
      check("csb",       csb,       exp_csb);
      check("cmd_ready", cmd_ready, exp_ready);
      check("rsp_valid", rsp_valid, exp_valid);
      check("rsp_nack",  rsp_nack,  exp_nack);
      check("rsp_rdat",  rsp_rdat,  exp_rdat);
    end
  end

  initial forever begin
    @(posedge sck_bus);
    if (cap_en) cap = {cap[7:0], sdo_bus};
  end

  initial forever begin
    @(posedge sdo_bus);
    if (rise_en) rise_sck = sck_bus;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    exp_sck = 1'b1; exp_sdo = 1'b1; exp_csb = 1'b1; exp_ready = 1'b1;
    exp_valid = 1'b0; exp_nack = 1'b0; exp_rdat = 8'h00; m_sck = 1'b1;
  endtask

  // Issue one command and step the model through every cycle of it; poke tries a command mid-flight.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] wdat, input logic ack,
                         input logic slave_ack, input logic [7:0] rx, input logic poke);
    int         len, b;
    logic [1:0] w;
    len = (op < 2'd2) ? 4 * CD : 36 * CD;
    w   = 2'b11;
    @(negedge clk);
    check("ready_before_cmd", cmd_ready, 1'b1);
    cmd_op = op; cmd_wdat = wdat; cmd_ack = ack; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      b = k / (4 * CD);
      w = wave(op, wdat, ack, k, m_sck);
      slave_sdo_low = 1'b0;
      if (op == OP_WRITE && b == 8) slave_sdo_low = slave_ack;
      if (op == OP_READ && b < 8)   slave_sdo_low = !rx[7-b];
      exp_sck = w[1]; exp_sdo = w[0] & !slave_sdo_low;
      exp_ready = 1'b0; exp_valid = 1'b0;
      if (op == OP_START) exp_csb = 1'b0;
      if (poke && k == 10) begin cmd_op = OP_STOP; cmd_valid = 1'b1; end
      else cmd_valid = 1'b0;
      @(posedge clk); #1;
    end
    m_sck = w[1];
    slave_sdo_low = 1'b0;
    exp_sdo = w[0]; exp_ready = 1'b1; exp_valid = (op >= OP_WRITE);
    if (op == OP_STOP)  exp_csb  = 1'b1;
    if (op == OP_WRITE) exp_nack = !slave_ack;
    if (op == OP_READ)  exp_rdat = rx;
    @(posedge clk); #1;
    exp_valid = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic done;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_wdat = 8'h00; cmd_ack = 1'b0;
    slave_sck_low = 1'b0; slave_sdo_low = 1'b0; cap = '0; rise_sck = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_sck",   sck_bus,   1'b1);
    check("reset_sdo",   sdo_bus,   1'b1);
    check("reset_csb",   csb,       1'b1);
    check("reset_ready", cmd_ready, 1'b1);
    check("reset_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_cmd(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    cap = '0; cap_en = 1'b1;
    run_cmd(OP_WRITE, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
    cap_en = 1'b0;
    check("wr_a5_bits", cap, 9'h14A);
    check("wr_a5_nack", rsp_nack, 1'b0);
    check("wr_a5_csb",  csb, 1'b0);

    run_cmd(OP_WRITE, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1);
    check("wr_5a_nack", rsp_nack, 1'b1);

    cap = '0; cap_en = 1'b1;
    run_cmd(OP_READ, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0);
    cap_en = 1'b0;
    check("rd_ack_rdat", rsp_rdat, 8'h3C);
    check("rd_ack_bits", cap, 9'h078);

    cap = '0; cap_en = 1'b1;
    run_cmd(OP_READ, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0);
    cap_en = 1'b0;
    check("rd_nack_bits", cap, 9'h079);

    rise_sck = 1'b0; rise_en = 1'b1;
    run_cmd(OP_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    rise_en = 1'b0;
    check("stop_sdo_rise_sck_high", rise_sck, 1'b1);
    check("stop_csb",   csb, 1'b1);
    check("stop_ready", cmd_ready, 1'b1);

    run_cmd(OP_WRITE, 8'h96, 1'b0, 1'b1, 8'h00, 1'b0);

    // Clock stretch: slave holds SCK low for 20 clocks from the release quarter of bit 3
    run_cmd(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b0;
    @(negedge clk);
    cmd_op = OP_WRITE; cmd_wdat = 8'hA5; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    done = 1'b0; cyc = -1;
    for (int k = 0; k < 400 && !done; k++) begin
      slave_sck_low = (k >= 3 * 4 * CD + CD) && (k < 3 * 4 * CD + CD + 20);
      @(negedge clk);
      if (rsp_valid) begin done = 1'b1; cyc = k; end
      @(posedge clk); #1;
    end
    slave_sck_low = 1'b0;
    check("stretch_done", done, 1'b1);
    check("stretch_len",  cyc, STRETCH_LEN);
    check("stretch_nack", rsp_nack, 1'b1);
    m_sck = 1'b0;
    exp_sck = 1'b0; exp_sdo = 1'b1; exp_csb = 1'b0; exp_nack = 1'b1;
    exp_ready = 1'b1; exp_valid = 1'b0;
    chk_en = 1'b1;
    run_cmd(OP_STOP, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a byte releases both lines at once and emits no STOP
    run_cmd(OP_START, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    chk_en = 1'b0;
    @(negedge clk);
    cmd_op = OP_WRITE; cmd_wdat = 8'h00; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_sck_low", sck_bus, 1'b0);
    check("mid_sdo_low", sdo_bus, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_sck",   sck_bus,   1'b1);
    check("rst_sdo",   sdo_bus,   1'b1);
    check("rst_csb",   csb,       1'b1);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_rdat",  rsp_rdat,  8'h00);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (20) @(posedge clk);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
